// File: rtl/deco_pipe.sv
// deco_pipe: decodes RV32 instruction words on enqueue and buffers the
// decoded fields in a 2-entry FIFO. The outputs come from the head entry.
// Optional feature: define DECO_ILLEGAL_EN to flag entries whose class is
// unknown or whose low opcode bits are not 2'b11. Without the macro,
// out_illegal is tied to 0.
module deco_pipe #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [6:0]      out_op,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic [2:0]      out_funct3,
  output logic [6:0]      out_funct7,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_type,
  output logic [XLEN-1:0] out_pc,
  output logic            out_illegal,
  output logic [1:0]      out_count
);

  typedef struct packed {
    logic [6:0]      op;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] imm;
    logic [2:0]      typ;
    logic [XLEN-1:0] pc;
  } entry_t;

  entry_t      mem [2];
  entry_t      dec_entry;
  entry_t      head;
  logic [2:0]  dec_type;
  logic [31:0] imm32;
  logic        wr_ptr_reg;
  logic        rd_ptr_reg;
  logic [1:0]  count_reg;
  logic        push;
  logic        pop;

  // Handshakes depend only on registered occupancy, never on out_ready.
  assign in_ready  = (count_reg != 2'd2);
  assign out_valid = (count_reg != 2'd0);
  assign out_count = count_reg;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Classify the incoming opcode into an instruction class.
  always_comb begin
    dec_type = 3'd0;
    case (in_instr[6:0])
      7'b0110011:                         dec_type = 3'd1;
      7'b0010011, 7'b0000011, 7'b1100111: dec_type = 3'd2;
      7'b0110111, 7'b0010111:             dec_type = 3'd3;
      7'b1100011:                         dec_type = 3'd4;
      7'b1101111:                         dec_type = 3'd5;
      7'b0100011:                         dec_type = 3'd6;
      default:                            dec_type = 3'd0;
    endcase
  end

  // Assemble the 32-bit immediate for the class, then sign-extend it to XLEN.
  always_comb begin
    imm32 = 32'd0;
    case (dec_type)
      3'd2: imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
      3'd6: imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      3'd4: imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                     in_instr[30:25], in_instr[11:8], 1'b0};
      3'd3: imm32 = {in_instr[31:12], 12'd0};
      3'd5: imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                     in_instr[20], in_instr[30:21], 1'b0};
      default: imm32 = 32'd0;
    endcase
    dec_entry        = '0;
    dec_entry.op     = in_instr[6:0];
    dec_entry.rd     = in_instr[11:7];
    dec_entry.funct3 = in_instr[14:12];
    dec_entry.rs1    = in_instr[19:15];
    dec_entry.rs2    = in_instr[24:20];
    dec_entry.funct7 = in_instr[31:25];
    dec_entry.imm    = XLEN'($signed(imm32));
    dec_entry.typ    = dec_type;
    dec_entry.pc     = in_pc;
  end

  // Occupancy and pointers; flush overrides any same-cycle push or pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg  <= 2'd0;
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
    end else if (flush) begin
      count_reg  <= 2'd0;
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
    end else begin
      if (push) wr_ptr_reg <= ~wr_ptr_reg;
      if (pop)  rd_ptr_reg <= ~rd_ptr_reg;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 2'd1;
        2'b01:   count_reg <= count_reg - 2'd1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Entry storage holds no reset: stale contents are masked by occupancy.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr_reg] <= dec_entry;
  end

  assign head = mem[rd_ptr_reg];

  // Present the head entry, forcing every data field to zero when empty.
  always_comb begin
    out_op     = '0;
    out_rs1    = '0;
    out_rs2    = '0;
    out_rd     = '0;
    out_funct3 = '0;
    out_funct7 = '0;
    out_imm    = '0;
    out_type   = '0;
    out_pc     = '0;
    if (out_valid) begin
      out_op     = head.op;
      out_rs1    = head.rs1;
      out_rs2    = head.rs2;
      out_rd     = head.rd;
      out_funct3 = head.funct3;
      out_funct7 = head.funct7;
      out_imm    = head.imm;
      out_type   = head.typ;
      out_pc     = head.pc;
    end
  end

`ifdef DECO_ILLEGAL_EN
  logic ill_mem [2];
  logic dec_illegal;

  assign dec_illegal = (dec_type == 3'd0) || (in_instr[1:0] != 2'b11);

  // Illegal flag travels alongside its entry so ordering is preserved.
  always_ff @(posedge clk) begin
    if (push && !flush) ill_mem[wr_ptr_reg] <= dec_illegal;
  end

  assign out_illegal = out_valid && ill_mem[rd_ptr_reg];
`else
  assign out_illegal = 1'b0;
`endif

endmodule

// File: tb/tb_deco_pipe.sv
// tb_deco_pipe: directed tests for deco_pipe at XLEN=32 plus a second
// instance at XLEN=64 for sign-extension width checks.
module tb_deco_pipe;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [6:0]  out_op;
  logic [4:0]  out_rs1;
  logic [4:0]  out_rs2;
  logic [4:0]  out_rd;
  logic [2:0]  out_funct3;
  logic [6:0]  out_funct7;
  logic [31:0] out_imm;
  logic [2:0]  out_type;
  logic [31:0] out_pc;
  logic        out_illegal;
  logic [1:0]  out_count;

  logic        w_in_valid;
  logic        w_in_ready;
  logic [31:0] w_in_instr;
  logic [63:0] w_in_pc;
  logic        w_out_valid;
  logic        w_out_ready;
  logic [6:0]  w_out_op;
  logic [4:0]  w_out_rs1;
  logic [4:0]  w_out_rs2;
  logic [4:0]  w_out_rd;
  logic [2:0]  w_out_funct3;
  logic [6:0]  w_out_funct7;
  logic [63:0] w_out_imm;
  logic [2:0]  w_out_type;
  logic [63:0] w_out_pc;
  logic        w_out_illegal;
  logic [1:0]  w_out_count;

  int vectors = 0;
  int miscompares = 0;

  deco_pipe #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_op(out_op), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
    .out_funct3(out_funct3), .out_funct7(out_funct7), .out_imm(out_imm),
    .out_type(out_type), .out_pc(out_pc), .out_illegal(out_illegal),
    .out_count(out_count)
  );

  deco_pipe #(.XLEN(64)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(1'b0),
    .in_valid(w_in_valid), .in_ready(w_in_ready), .in_instr(w_in_instr), .in_pc(w_in_pc),
    .out_valid(w_out_valid), .out_ready(w_out_ready),
    .out_op(w_out_op), .out_rs1(w_out_rs1), .out_rs2(w_out_rs2), .out_rd(w_out_rd),
    .out_funct3(w_out_funct3), .out_funct7(w_out_funct7), .out_imm(w_out_imm),
    .out_type(w_out_type), .out_pc(w_out_pc), .out_illegal(w_out_illegal),
    .out_count(w_out_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef DECO_ILLEGAL_EN
  localparam logic ILL_ZERO_EXP = 1'b1;
`else
  localparam logic ILL_ZERO_EXP = 1'b0;
`endif

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [31:0] w, input logic [31:0] pc);
    in_valid = 1'b1;
    in_instr = w;
    in_pc    = pc;
    step();
    in_valid = 1'b0;
    $display("push instr=%08h pc=%08h count=%0d", w, pc, out_count);
  endtask

  task automatic pop_one();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    $display("pop  count=%0d", out_count);
  endtask

  task automatic test_reset();
    #2;
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_out_valid got %0b want 0", out_valid); end
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL rst_in_ready got %0b want 1", in_ready); end
    vectors++; if (out_count !== 2'd0) begin miscompares++; $display("FAIL rst_count got %0d want 0", out_count); end
    vectors++; if (out_imm !== 32'd0) begin miscompares++; $display("FAIL rst_imm got %08h want 0", out_imm); end
    vectors++; if (out_illegal !== 1'b0) begin miscompares++; $display("FAIL rst_illegal got %0b want 0", out_illegal); end
    vectors++; if (w_out_valid !== 1'b0) begin miscompares++; $display("FAIL rst64_out_valid got %0b want 0", w_out_valid); end
    step();
    rst_n = 1'b1;
    step();
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL post_rst_in_ready got %0b want 1", in_ready); end
    $display("test_reset done");
  endtask

  task automatic test_addi();
    push_one(32'hFFF10093, 32'h0000_0100);
    vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL addi_valid got %0b want 1", out_valid); end
    vectors++; if (out_count !== 2'd1) begin miscompares++; $display("FAIL addi_count got %0d want 1", out_count); end
    vectors++; if (out_type !== 3'd2) begin miscompares++; $display("FAIL addi_type got %0d want 2", out_type); end
    vectors++; if (out_rd !== 5'd1) begin miscompares++; $display("FAIL addi_rd got %0d want 1", out_rd); end
    vectors++; if (out_rs1 !== 5'd2) begin miscompares++; $display("FAIL addi_rs1 got %0d want 2", out_rs1); end
    vectors++; if (out_imm !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL addi_imm got %08h want ffffffff", out_imm); end
    vectors++; if (out_op !== 7'h13) begin miscompares++; $display("FAIL addi_op got %02h want 13", out_op); end
    vectors++; if (out_pc !== 32'h100) begin miscompares++; $display("FAIL addi_pc got %08h want 00000100", out_pc); end
    pop_one();
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL addi_drain_valid got %0b want 0", out_valid); end
    vectors++; if (out_imm !== 32'd0) begin miscompares++; $display("FAIL addi_drain_imm got %08h want 0", out_imm); end
    vectors++; if (out_op !== 7'd0) begin miscompares++; $display("FAIL addi_drain_op got %02h want 0", out_op); end
  endtask

  task automatic test_decode();
    logic [31:0] words [7];
    logic [2:0]  types [7];
    logic [31:0] imms  [7];
    words = '{32'hFE000EE3, 32'h008000EF, 32'h0020A223, 32'h002081B3,
              32'h123452B7, 32'hFF80A183, 32'h00000000};
    types = '{3'd4, 3'd5, 3'd6, 3'd1, 3'd3, 3'd2, 3'd0};
    imms  = '{32'hFFFFFFFC, 32'h00000008, 32'h00000004, 32'h00000000,
              32'h12345000, 32'hFFFFFFF8, 32'h00000000};
    for (int i = 0; i < 7; i++) begin
      push_one(words[i], 32'h1000 + 32'(i * 4));
      vectors++; if (out_type !== types[i]) begin miscompares++; $display("FAIL dec_type[%0d] got %0d want %0d", i, out_type, types[i]); end
      vectors++; if (out_imm !== imms[i]) begin miscompares++; $display("FAIL dec_imm[%0d] got %08h want %08h", i, out_imm, imms[i]); end
      if (i == 2) begin
        vectors++; if (out_rs1 !== 5'd1 || out_rs2 !== 5'd2 || out_funct3 !== 3'd2) begin miscompares++; $display("FAIL sw_fields got rs1=%0d rs2=%0d f3=%0d want 1 2 2", out_rs1, out_rs2, out_funct3); end
      end
      if (i == 6) begin
        vectors++; if (out_illegal !== ILL_ZERO_EXP) begin miscompares++; $display("FAIL zero_illegal got %0b want %0b", out_illegal, ILL_ZERO_EXP); end
      end else begin
        vectors++; if (out_illegal !== 1'b0) begin miscompares++; $display("FAIL dec_illegal[%0d] got %0b want 0", i, out_illegal); end
      end
      pop_one();
    end
  endtask

  task automatic test_back_to_back();
    in_valid = 1'b1;
    in_instr = 32'hFFF10093; in_pc = 32'hA0; step();
    in_instr = 32'hFE000EE3; in_pc = 32'hA4; step();
    in_instr = 32'h008000EF; in_pc = 32'hA8; step();
    $display("b2b three pushes offered, count=%0d", out_count);
    vectors++; if (out_count !== 2'd2) begin miscompares++; $display("FAIL b2b_count got %0d want 2", out_count); end
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL b2b_in_ready got %0b want 0", in_ready); end
    vectors++; if (out_pc !== 32'hA0) begin miscompares++; $display("FAIL b2b_head got %08h want 000000a0", out_pc); end
    step();
    vectors++; if (out_pc !== 32'hA0 || out_type !== 3'd2) begin miscompares++; $display("FAIL b2b_stable got pc=%08h type=%0d want a0 2", out_pc, out_type); end
    out_ready = 1'b1;
    step();
    vectors++; if (out_pc !== 32'hA4 || out_count !== 2'd1) begin miscompares++; $display("FAIL b2b_pop1 got pc=%08h cnt=%0d want a4 1", out_pc, out_count); end
    step();
    vectors++; if (out_pc !== 32'hA8 || out_count !== 2'd1 || out_type !== 3'd5) begin miscompares++; $display("FAIL b2b_pushpop got pc=%08h cnt=%0d type=%0d want a8 1 5", out_pc, out_count, out_type); end
    in_valid = 1'b0;
    step();
    out_ready = 1'b0;
    vectors++; if (out_count !== 2'd0 || out_valid !== 1'b0) begin miscompares++; $display("FAIL b2b_drain got cnt=%0d valid=%0b want 0 0", out_count, out_valid); end
    $display("b2b drained count=%0d", out_count);
  endtask

  task automatic test_flush();
    push_one(32'h002081B3, 32'hB0);
    push_one(32'h0020A223, 32'hB4);
    flush = 1'b1; in_valid = 1'b1; in_instr = 32'hFFF10093; in_pc = 32'hB8;
    step();
    flush = 1'b0; in_valid = 1'b0;
    $display("flush at count 2, count=%0d", out_count);
    vectors++; if (out_count !== 2'd0) begin miscompares++; $display("FAIL flush2_count got %0d want 0", out_count); end
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL flush2_valid got %0b want 0", out_valid); end
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL flush2_in_ready got %0b want 1", in_ready); end
    step();
    vectors++; if (out_count !== 2'd0) begin miscompares++; $display("FAIL flush2_dropped got %0d want 0", out_count); end
    push_one(32'h002081B3, 32'hC0);
    flush = 1'b1; in_valid = 1'b1; out_ready = 1'b1; in_instr = 32'hFFF10093; in_pc = 32'hC4;
    step();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    $display("flush at count 1 with push and pop, count=%0d", out_count);
    vectors++; if (out_count !== 2'd0) begin miscompares++; $display("FAIL flush1_count got %0d want 0", out_count); end
    push_one(32'h123452B7, 32'hC8);
    vectors++; if (out_pc !== 32'hC8 || out_count !== 2'd1) begin miscompares++; $display("FAIL flush_after got pc=%08h cnt=%0d want c8 1", out_pc, out_count); end
    pop_one();
  endtask

  task automatic test_reset_midstream();
    push_one(32'hFE000EE3, 32'hD0);
    rst_n = 1'b0;
    #1;
    $display("reset asserted mid-stream, count=%0d", out_count);
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL midrst_valid got %0b want 0", out_valid); end
    vectors++; if (out_pc !== 32'd0) begin miscompares++; $display("FAIL midrst_pc got %08h want 0", out_pc); end
    step();
    rst_n = 1'b1;
    step();
    vectors++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin miscompares++; $display("FAIL midrst_release got valid=%0b ready=%0b want 0 1", out_valid, in_ready); end
    push_one(32'h008000EF, 32'hD4);
    vectors++; if (out_pc !== 32'hD4 || out_count !== 2'd1) begin miscompares++; $display("FAIL midrst_first got pc=%08h cnt=%0d want d4 1", out_pc, out_count); end
    pop_one();
  endtask

  task automatic test_xlen64();
    w_in_valid = 1'b1; w_in_instr = 32'hFFF10093; w_in_pc = 64'h1_0000_0000;
    step();
    w_in_valid = 1'b0;
    $display("push64 instr=%08h count=%0d", w_in_instr, w_out_count);
    vectors++; if (w_out_valid !== 1'b1) begin miscompares++; $display("FAIL x64_valid got %0b want 1", w_out_valid); end
    vectors++; if (w_out_type !== 3'd2 || w_out_rd !== 5'd1 || w_out_rs1 !== 5'd2) begin miscompares++; $display("FAIL x64_fields got type=%0d rd=%0d rs1=%0d want 2 1 2", w_out_type, w_out_rd, w_out_rs1); end
    vectors++; if (w_out_imm !== 64'hFFFF_FFFF_FFFF_FFFF) begin miscompares++; $display("FAIL x64_imm got %016h want ffffffffffffffff", w_out_imm); end
    vectors++; if (w_out_pc !== 64'h1_0000_0000) begin miscompares++; $display("FAIL x64_pc got %016h want 0000000100000000", w_out_pc); end
    w_out_ready = 1'b1; w_in_valid = 1'b1; w_in_instr = 32'hFE000EE3;
    step();
    w_in_valid = 1'b0; w_out_ready = 1'b0;
    vectors++; if (w_out_imm !== 64'hFFFF_FFFF_FFFF_FFFC || w_out_type !== 3'd4) begin miscompares++; $display("FAIL x64_beq got imm=%016h type=%0d want fffffffffffffffc 4", w_out_imm, w_out_type); end
    w_out_ready = 1'b1;
    step();
    w_out_ready = 1'b0;
    vectors++; if (w_out_valid !== 1'b0 || w_out_imm !== 64'd0) begin miscompares++; $display("FAIL x64_drain got valid=%0b imm=%016h want 0 0", w_out_valid, w_out_imm); end
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = 32'd0; in_pc = 32'd0;
    w_in_valid = 1'b0; w_out_ready = 1'b0; w_in_instr = 32'd0; w_in_pc = 64'd0;
    test_reset();
    test_addi();
    test_decode();
    test_back_to_back();
    test_flush();
    test_reset_midstream();
    test_xlen64();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
